// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared types and digit codes for the seven-segment scan controller
package seven_segment_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_t;

   localparam int CODE_W = 3;

   localparam logic [CODE_W-1:0] ZERO  = 3'b000;
   localparam logic [CODE_W-1:0] ONE   = 3'b001;
   localparam logic [CODE_W-1:0] TWO   = 3'b010;
   localparam logic [CODE_W-1:0] THREE = 3'b011;
   localparam logic [CODE_W-1:0] ERR   = 3'b100;

endpackage

// File: rtl/seven_segment_scan_cntrl_if.sv
// rtl/seven_segment_scan_cntrl_if.sv - load/scan signal bundle between multiplier status logic and the display scanner
interface seven_segment_scan_cntrl_if
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS = 4
);
   logic                         en;
   logic                         load;
   logic [CODE_W*NUM_DIGITS-1:0] load_data;
   logic                         load_ack;
   logic [CODE_W-1:0]            dig_code;
   logic [NUM_DIGITS-1:0]        digit_sel;
   logic                         frame_done;

   modport master (
      output en, load, load_data,
      input  load_ack, dig_code, digit_sel, frame_done
   );

   modport slave (
      input  en, load, load_data,
      output load_ack, dig_code, digit_sel, frame_done
   );
endinterface

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - loadable down-counter timing the blank and dwell intervals
module scan_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);
   logic [W-1:0] count;

   // Loading N-1 makes tc assert on the Nth cycle after the load.
   assign tc = (count == '0);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/seven_segment_scan_cntrl.sv
// rtl/seven_segment_scan_cntrl.sv - multiplexed digit scanner with blanking and frame-aligned double buffering
module seven_segment_scan_cntrl
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int DWELL_CYCLES   = 50000,
   parameter int BLANK_CYCLES   = 500,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input logic                      clk,
   input logic                      rst,
   seven_segment_scan_cntrl_if.slave bus
);
   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int TMR_W   = $clog2(MAX_CYC + 1);

   localparam logic [TMR_W-1:0]      BLANK_LOAD = TMR_W'(BLANK_CYCLES - 1);
   localparam logic [TMR_W-1:0]      DWELL_LOAD = TMR_W'(DWELL_CYCLES - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] SEL_OFF    = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

   typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] disp_t;

   scan_state_t           state, state_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   disp_t                 display, display_nxt;
   disp_t                 pending, pending_nxt;
   logic                  pending_valid, pending_valid_nxt;
   logic [CODE_W-1:0]     dig_code, dig_code_nxt;
   logic [NUM_DIGITS-1:0] digit_sel, digit_sel_nxt, sel_oh;
   logic                  load_ack, load_ack_nxt;
   logic                  frame_done, frame_done_nxt;
   logic                  commit;
   logic                  tmr_clr, tmr_load, tmr_tc;
   logic [TMR_W-1:0]      tmr_val;

   scan_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (tmr_clr),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_comb begin
      state_nxt         = state;
      idx_nxt           = idx;
      display_nxt       = display;
      pending_nxt       = pending;
      pending_valid_nxt = pending_valid;
      dig_code_nxt      = dig_code;
      load_ack_nxt      = 1'b0;
      frame_done_nxt    = 1'b0;
      commit            = 1'b0;
      tmr_clr           = 1'b0;
      tmr_load          = 1'b0;
      tmr_val           = BLANK_LOAD;
      sel_oh            = '0;

      if (!bus.en) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         tmr_clr   = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = BLANK;
               idx_nxt   = '0;
               tmr_load  = 1'b1;
               commit    = 1'b1;
            end
            BLANK: begin
               if (tmr_tc) begin
                  state_nxt = SHOW;
                  tmr_load  = 1'b1;
                  tmr_val   = DWELL_LOAD;
               end
            end
            SHOW: begin
               if (tmr_tc) begin
                  state_nxt = BLANK;
                  tmr_load  = 1'b1;
                  if (idx == IDX_LAST) begin
                     idx_nxt        = '0;
                     frame_done_nxt = 1'b1;
                     commit         = 1'b1;
                  end else begin
                     idx_nxt = idx + 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      // A load landing on a commit cycle bypasses the pending buffer so the newest value wins.
      if (commit) begin
         if (bus.load) begin
            display_nxt       = bus.load_data;
            pending_valid_nxt = 1'b0;
            load_ack_nxt      = 1'b1;
         end else if (pending_valid) begin
            display_nxt       = pending;
            pending_valid_nxt = 1'b0;
            load_ack_nxt      = 1'b1;
         end
      end else if (bus.load) begin
         pending_nxt       = bus.load_data;
         pending_valid_nxt = 1'b1;
      end

      if (state_nxt != IDLE) dig_code_nxt = display_nxt[idx_nxt];
      if (state_nxt == SHOW) sel_oh[idx_nxt] = 1'b1;
      digit_sel_nxt = (SEL_ACTIVE_LOW != 0) ? ~sel_oh : sel_oh;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         display       <= '0;
         pending       <= '0;
         pending_valid <= 1'b0;
         dig_code      <= ZERO;
         digit_sel     <= SEL_OFF;
         load_ack      <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         state         <= state_nxt;
         idx           <= idx_nxt;
         display       <= display_nxt;
         pending       <= pending_nxt;
         pending_valid <= pending_valid_nxt;
         dig_code      <= dig_code_nxt;
         digit_sel     <= digit_sel_nxt;
         load_ack      <= load_ack_nxt;
         frame_done    <= frame_done_nxt;
      end
   end

   assign bus.dig_code   = dig_code;
   assign bus.digit_sel  = digit_sel;
   assign bus.load_ack   = load_ack;
   assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_seven_segment_scan_cntrl.sv
// tb/tb_seven_segment_scan_cntrl.sv - scoreboard bench for the seven-segment scan controller
module tb_seven_segment_scan_cntrl;
   localparam int ND    = 4;
   localparam int DWELL = 3;
   localparam int BLK   = 2;
   localparam int SLOT  = DWELL + BLK;
   localparam int FRAME = ND * SLOT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seven_segment_scan_cntrl_if #(.NUM_DIGITS(ND)) bus ();

   seven_segment_scan_cntrl #(
      .NUM_DIGITS     (ND),
      .DWELL_CYCLES   (DWELL),
      .BLANK_CYCLES   (BLK),
      .SEL_ACTIVE_LOW (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   logic [8:0] exp_q[$];

   bit          m_run, m_pv, m_ack, m_fd;
   int          m_pos;
   logic [11:0] m_disp, m_pend;
   logic [2:0]  m_code;
   logic [3:0]  m_sel;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: position within the frame, digit and phase derived arithmetically.
   task automatic model(input bit e, input bit ld, input logic [11:0] d, input bit r);
      bit commit;
      commit = 1'b0;
      m_ack  = 1'b0;
      m_fd   = 1'b0;
      if (r) begin
         m_run = 0; m_pos = 0; m_disp = '0; m_pend = '0; m_pv = 0; m_code = '0;
      end else begin
         if (!e) begin
            m_run = 0; m_pos = 0;
         end else if (!m_run) begin
            m_run = 1; m_pos = 0; commit = 1'b1;
         end else if (m_pos == FRAME - 1) begin
            m_pos = 0; m_fd = 1; commit = 1'b1;
         end else begin
            m_pos++;
         end
         if (commit) begin
            if (ld) begin
               m_disp = d; m_pv = 0; m_ack = 1;
            end else if (m_pv) begin
               m_disp = m_pend; m_pv = 0; m_ack = 1;
            end
         end else if (ld) begin
            m_pend = d; m_pv = 1;
         end
         if (m_run) m_code = m_disp[3*(m_pos/SLOT) +: 3];
      end
      if (m_run && (m_pos % SLOT) >= BLK) m_sel = ~(4'b0001 << (m_pos / SLOT));
      else m_sel = 4'b1111;
   endtask

   task automatic step(input bit e, input bit ld, input logic [11:0] d, input bit r);
      logic [8:0] exp;
      @(negedge clk);
      rst           = r;
      bus.en        = e;
      bus.load      = ld;
      bus.load_data = d;
      model(e, ld, d, r);
      exp_q.push_back({m_code, m_sel, m_ack, m_fd});
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check($sformatf("cyc%0d code/sel/ack/fd", cyc),
            16'({bus.dig_code, bus.digit_sel, bus.load_ack, bus.frame_done}), 16'(exp));
      cyc++;
   endtask

   task automatic run(input int n, input bit e);
      for (int k = 0; k < n; k++) step(e, 1'b0, 12'h000, 1'b0);
   endtask

   task automatic run_to(input int target);
      for (int k = 0; k < 2 * FRAME && !(m_run && m_pos == target); k++)
         step(1'b1, 1'b0, 12'h000, 1'b0);
   endtask

   initial begin
      bus.en        = 1'b0;
      bus.load      = 1'b0;
      bus.load_data = '0;

      step(1'b0, 1'b0, 12'h000, 1'b1);
      step(1'b0, 1'b0, 12'h000, 1'b1);
      run(3, 1'b0);

      // Load while idle, then start: commit and ack on the start cycle.
      step(1'b0, 1'b1, 12'b011_010_001_000, 1'b0);
      run(2 * FRAME + 5, 1'b1);

      // Two mid-frame loads: last wins, one ack at the wrap, digit 0 shows ERR.
      run(5, 1'b1);
      step(1'b1, 1'b1, 12'h249, 1'b0);
      run(3, 1'b1);
      step(1'b1, 1'b1, 12'h924, 1'b0);
      run(FRAME + 5, 1'b1);
      check("err_glyph_digit0", 16'(m_disp[2:0]), 16'(3'b100));

      // Load landing exactly on the wrap edge.
      run_to(FRAME - 1);
      step(1'b1, 1'b1, 12'h53A, 1'b0);
      check("wrap_load_fd", 16'(bus.frame_done), 16'd1);
      check("wrap_load_ack", 16'(bus.load_ack), 16'd1);
      check("wrap_load_code", 16'(bus.dig_code), 16'(3'b010));
      run(FRAME + 2, 1'b1);

      // Drop enable during SHOW of digit 2, then restart.
      run_to(2 * SLOT + BLK);
      step(1'b0, 1'b0, 12'h000, 1'b0);
      check("en_drop_sel_off", 16'(bus.digit_sel), 16'hF);
      run(2, 1'b0);
      run(FRAME + 5, 1'b1);

      // Reset during SHOW with a pending value: it must be discarded.
      run_to(BLK);
      step(1'b1, 1'b1, 12'h777, 1'b0);
      step(1'b1, 1'b0, 12'h000, 1'b1);
      run(FRAME + 5, 1'b1);
      check("rst_discard_code", 16'(bus.dig_code), 16'(3'b000));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/seven_segment_scan_cntrl.md
Name: seven_segment_scan_cntrl

Overview:
- Time-multiplexes NUM_DIGITS 3-bit digit codes onto one shared seven-segment decoder and a common-segment display.
- Cycles through the digits: drives the decoder input and one digit-select line at a time.
- Inserts a blanking interval before each digit to suppress ghosting.
- Double-buffers new display values so they change only on a frame boundary.
- Sits between the sequential multiplier's result/status logic and the existing decoder; the decoder is instantiated next to it at top level.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2)
DWELL_CYCLES, 50000, clk cycles each digit is lit (>=1)
BLANK_CYCLES, 500, clk cycles all digits are off before each digit (>=1)
SEL_ACTIVE_LOW, 1, 1: digit_sel asserted low; 0: asserted high

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  scanning enable
load  input  1  one-cycle strobe: capture load_data into pending buffer
load_data  input  3*NUM_DIGITS  digit codes; digit i = bits [3i+2:3i]
load_ack  output  1  one-cycle pulse when a value is committed to display
dig_code  output  3  code to the shared decoder input
digit_sel  output  NUM_DIGITS  per-digit enable, polarity per SEL_ACTIVE_LOW
frame_done  output  1  one-cycle pulse at the end of each full scan

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values:
  - state = IDLE, digit index = 0, timer = 0.
  - Display register = 0, pending_valid = 0.
  - dig_code = 3'b000, digit_sel = all inactive, load_ack = 0, frame_done = 0.
- FSM states: IDLE, BLANK, SHOW.
- IDLE:
  - All digit_sel inactive.
  - en=1 -> BLANK, idx=0, dig_code=display[0], timer=0.
- BLANK:
  - All digit_sel inactive; dig_code holds display[idx].
  - After exactly BLANK_CYCLES cycles -> SHOW.
- SHOW:
  - Only digit_sel[idx] is active, for exactly DWELL_CYCLES cycles.
  - If idx<NUM_DIGITS-1: -> BLANK, idx+1, dig_code=display[idx+1].
  - If idx=NUM_DIGITS-1: wrap. -> BLANK, idx=0, frame_done=1 for one cycle, then commit (below).
- Frame length = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- en deasserted in any state: next cycle -> IDLE, digit_sel all inactive, idx=0, timer cleared. No frame_done is generated and no commit occurs.
- load:
  - Copies load_data into the pending buffer and sets pending_valid.
  - A repeated load before commit overwrites the buffer; the last value wins and only one load_ack is produced.
- Commit:
  - Happens in the wrap cycle and also in the IDLE->BLANK start cycle.
  - If pending_valid: display <= pending, pending_valid <= 0, load_ack=1 for one cycle.
  - dig_code for digit 0 in that same cycle reflects the newly committed value.
- load coincident with a commit cycle: load_data is committed directly (newest wins), pending_valid ends 0, one load_ack.
- load while IDLE: held pending, committed on the next IDLE->BLANK.
- Codes are passed through unmodified. Codes >=3'b100 render as the decoder's error glyph; the controller does no checking.
- Timer width = clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1); it must not overflow at default values.
- digit_sel is never active in more than one bit in any cycle, and never active during BLANK or IDLE.

Decomposition:
- Package seven_segment_pkg:
  - Scan state enum {IDLE, BLANK, SHOW}.
  - Digit code width constant (3).
  - Named digit codes: ZERO=3'b000, ONE=3'b001, TWO=3'b010, THREE=3'b011, ERR=3'b100.
- One sub-module, scan_timer: loadable down-counter with a terminal-count pulse, reused for the BLANK and SHOW intervals.

Test Plan:
- Reset, then 3 idle cycles -> digit_sel all inactive, dig_code=000, load_ack=0, frame_done=0.
- NUM_DIGITS=4, DWELL=3, BLANK=2, load_data=12'b011_010_001_000, load, en=1:
  - load_ack on the start cycle.
  - Pattern per digit: 2 blank cycles, then digit_sel active one-hot for 3 cycles, with dig_code 000,001,010,011 in turn.
  - frame_done pulses every 20 cycles.
- Two loads mid-frame (0x249, then 0x924) -> display unchanged until the wrap; exactly one load_ack at the wrap; digit 0 then shows 3'b100 from the 0x924 value.
- load asserted in the exact wrap cycle -> that load_data is shown from digit 0 in the same frame, one load_ack, pending_valid=0 afterwards.
- en dropped during SHOW of digit 2 -> next cycle all digit_sel inactive and no frame_done. en re-asserted -> scan restarts with BLANK on digit 0.
- rst asserted during SHOW with pending_valid=1 -> next cycle all reset values; the pending data is discarded and no load_ack occurs after release.
